vga_scan_controller: RTL and testbench

- Sequences the frame-border datapath (frame_detection) from the VGA pixel timing.
- Generates 640x480@60 timing and the row/column position inputs: x_pos = row 0..479, y_pos = column 0..639.
- Owns the frame-width register W and accepts W updates through a req/ack handshake.
- Commits W only at the start of vertical blanking, so a visible frame is never drawn with two widths.

---
 rtl/vga_scan_controller.sv | 157 +++++++++++++++
 tb/tb_vga_scan_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// VGA scan timing and frame-width register W. Decodes are zero-latency; W requests wait in PEND until the next vblank.
// Optional `SYNC_ALIGN_EN: hsync_n/vsync_n/active get one extra pix_en register stage to line up with a registered colour path.
module vga_scan_controller #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int W_RESET   = 10,
  parameter int MAX_W     = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_req,
  input  logic [5:0] w_in,
  output logic       w_ack,
  output logic [5:0] W,
  output logic [8:0] x_pos,
  output logic [9:0] y_pos,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_wrap;
  logic             active_raw;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             commit;

  state_t           state;
  state_t           state_nxt;
  logic             load_lat;
  logic             load_w;
  logic [5:0]       w_lat;
  logic [5:0]       w_clamped;

  // With CLK_DIV=1 the divider is stuck at 0, which equals CLK_DIV-1, so pix_en stays high.
  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_wrap = (h_cnt == 10'(H_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign active_raw  = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
  assign hsync_raw   = !((h_cnt >= 10'(H_VISIBLE + H_FP)) && (h_cnt < 10'(H_VISIBLE + H_FP + H_SYNC)));
  assign vsync_raw   = !((v_cnt >= 10'(V_VISIBLE + V_FP)) && (v_cnt < 10'(V_VISIBLE + V_FP + V_SYNC)));
  assign x_pos       = active_raw ? v_cnt[8:0] : '0;
  assign y_pos       = active_raw ? h_cnt : '0;
  assign frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Last clock of the last visible line: W switches while the beam is in vblank.
  assign commit = pix_en && h_wrap && (v_cnt == 10'(V_VISIBLE - 1));

`ifdef SYNC_ALIGN_EN
  logic hs_q;
  logic vs_q;
  logic act_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
    end else if (pix_en) begin
      hs_q  <= hsync_raw;
      vs_q  <= vsync_raw;
      act_q <= active_raw;
    end
  end

  assign hsync_n = rst | hs_q;
  assign vsync_n = rst | vs_q;
  assign active  = act_q;
`else
  assign hsync_n = rst | hsync_raw;
  assign vsync_n = rst | vsync_raw;
  assign active  = active_raw;
`endif

  assign w_clamped = (w_in > 6'(MAX_W)) ? 6'(MAX_W) : w_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_ack     = 1'b0;
    load_lat  = 1'b0;
    load_w    = 1'b0;
    case (state)
      IDLE: begin
        if (w_req) begin
          load_lat  = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (commit) begin
          load_w    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        w_ack     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_lat <= 6'(W_RESET);
      W     <= 6'(W_RESET);
    end else begin
      if (load_lat) w_lat <= w_clamped;
      if (load_w)   W     <= w_lat;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller on a shrunken raster; expected outputs come from cycle arithmetic and a scheduled-commit model of W.
module tb_vga_scan_controller;

  localparam int CD  = 2;
  localparam int HV  = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VV  = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int WR  = 10;
  localparam int MW  = 40;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int FRAME      = HT * VT * CD;
  localparam int COMMIT_OFF = ((VV - 1) * HT + HT - 1) * CD + CD - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_req = 1'b0;
  logic [5:0] w_in = '0;
  logic       w_ack;
  logic [5:0] w_dut;
  logic [8:0] x_pos;
  logic [9:0] y_pos;
  logic       active;
  logic       hsync_n;
  logic       vsync_n;
  logic       frame_start;

  vga_scan_controller #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .W_RESET(WR), .MAX_W(MW)
  ) dut (
    .clk(clk), .rst(rst), .w_req(w_req), .w_in(w_in), .w_ack(w_ack), .W(w_dut),
    .x_pos(x_pos), .y_pos(y_pos), .active(active), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model / requester state
  int n, exp_w, pend, pend_val, ack_cycle;
  int req_on, req_val, hold_past;
  int last_fs, hs_start, vs_start, acks, last_ack_n;
  bit prev_hs, prev_vs;
  logic [5:0] prev_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, n);
    end
  endtask

  function automatic int next_commit(input int c);
    int k;
    k = c - (c % FRAME) + COMMIT_OFF;
    if (k <= c) k += FRAME;
    return k;
  endfunction

  // Compare cycle n at its negedge, then drive the inputs sampled at the end of cycle n.
  task automatic tick();
    int pix, hc, vc;
    bit pe, act, ack_e;
    pix   = n / CD;
    hc    = pix % HT;
    vc    = (pix / HT) % VT;
    pe    = (n % CD) == CD - 1;
    act   = (hc < HV) && (vc < VV);
    ack_e = (n == ack_cycle);
    if (ack_e) exp_w = pend_val;

    check("active",      active,      act);
    check("x_pos",       x_pos,       act ? vc : 0);
    check("y_pos",       y_pos,       act ? hc : 0);
    check("hsync_n",     hsync_n,     !((hc >= HV + HFP) && (hc < HV + HFP + HS)));
    check("vsync_n",     vsync_n,     !((vc >= VV + VFP) && (vc < VV + VFP + VS)));
    check("frame_start", frame_start, pe && hc == 0 && vc == 0);
    check("w_ack",       w_ack,       ack_e);
    check("W",           w_dut,       exp_w);

    if (w_dut !== prev_w) check("w_change_while_active", active, 0);
    prev_w = w_dut;
    if (w_ack === 1'b1) begin
      acks++;
      last_ack_n = n;
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("frame_period", n - last_fs, FRAME);
      last_fs = n;
    end
    if (hsync_n === 1'b0 && prev_hs) hs_start = n;
    if (hsync_n === 1'b1 && !prev_hs && hs_start >= 0) check("hsync_width", n - hs_start, HS * CD);
    prev_hs = (hsync_n === 1'b1);
    if (vsync_n === 1'b0 && prev_vs) vs_start = n;
    if (vsync_n === 1'b1 && !prev_vs && vs_start >= 0) check("vsync_width", n - vs_start, VS * HT * CD);
    prev_vs = (vsync_n === 1'b1);

    w_req = (req_on != 0);
    w_in  = 6'(req_val);
    if (!pend && !ack_e && req_on != 0) begin
      pend      = 1;
      pend_val  = (req_val > MW) ? MW : req_val;
      ack_cycle = next_commit(n) + 1;
    end
    if (ack_e) begin
      pend = 0;
      if (hold_past > 0) hold_past--;
      else req_on = 0;
    end
    n++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    w_req = 1'b0;
    #1;
    check("hsync_n_in_reset", hsync_n, 1);
    check("vsync_n_in_reset", vsync_n, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0; exp_w = WR; pend = 0; pend_val = WR; ack_cycle = -1;
    req_on = 0; hold_past = 0;
    last_fs = -1; hs_start = -1; vs_start = -1;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_w = 6'(WR);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic run_to(input int off);
    while ((n % FRAME) != off) tick();
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (req_on != 0 && i < budget) begin
      tick();
      i++;
    end
    check("request_completes", req_on, 0);
  endtask

  initial begin
    int a0, start;
    acks = 0; last_ack_n = -1; req_val = 0;
    @(negedge clk);
    apply_reset();

    // idle frames: timing, W stays at reset value, no ack
    run(2 * FRAME + 20);
    check("no_ack_idle", acks, 0);
    check("W_idle", w_dut, WR);

    // mid-frame request, committed at vblank start
    run_to(3 * HT * CD + 10);
    req_val = 20; req_on = 1;
    wait_done(3 * FRAME);
    run(10);
    check("W_update", w_dut, 20);

    // clamp
    req_val = 63; req_on = 1;
    wait_done(3 * FRAME);
    run(10);
    check("W_clamped", w_dut, MW);

    // zero width is legal
    req_val = 0; req_on = 1;
    wait_done(3 * FRAME);
    run(10);
    check("W_zero", w_dut, 0);

    // w_req held one cycle past w_ack: re-latched, second ack a frame later
    a0 = acks;
    req_val = 33; req_on = 1; hold_past = 1;
    wait_done(4 * FRAME);
    run(10);
    check("ack_count_back_to_back", acks - a0, 2);
    check("W_back_to_back", w_dut, 33);

    // request arriving on the commit clock waits a full frame
    run_to(COMMIT_OFF);
    start = n;
    req_val = 7; req_on = 1;
    wait_done(3 * FRAME);
    check("commit_clock_latency", last_ack_n - start, FRAME + 1);

    // w_in changes while pending are ignored
    run(5);
    req_val = 25; req_on = 1;
    run(3);
    req_val = 3;
    wait_done(3 * FRAME);
    run(5);
    check("pend_ignores_w_in", w_dut, 25);

    // reset while pending discards the request
    req_val = 5; req_on = 1;
    run(20);
    apply_reset();
    a0 = acks;
    run(FRAME + 20);
    check("no_ack_after_reset", acks - a0, 0);
    check("W_after_reset", w_dut, WR);

    // randomized requests
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, FRAME - 1));
      req_val   = $urandom_range(0, 63);
      hold_past = $urandom_range(0, 1);
      req_on    = 1;
      wait_done(4 * FRAME);
    end
    run(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
